read_channel: RTL and testbench

READ_CHANNEL -- requirements
Module: read_channel

---
 rtl/read_channel.sv | 178 +++++++++++++++++
 tb/tb_read_channel.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_channel.sv
// read_channel
// Single-burst AXI4 read master feeding an AXI4-Stream output.
// A rising edge on read_start_i latches address, length and size. The block
// then issues one INCR burst on the AR channel and forwards every R beat to
// the stream. R and stream are tied together combinationally in DATA, so
// stream backpressure stalls the read data channel directly.
//
// Ports
//   m_axi_aclk, m_axi_aresetn    clock, asynchronous active-low reset
//   m_mm2s_axi_ar*               AR channel (address, burst/cache/prot, len, size, handshake)
//   m_mm2s_axi_r*                R channel (data, resp, last, handshake)
//   m_mm2s_axis_t*               output stream (data, valid, last, ready)
//   read_start_i                 start request, rising-edge sensitive
//   read_addr_i/len_i/size_i     burst parameters, sampled on the start edge
//   read_busy_o                  high while a burst is in flight (ADDR or DATA)
//   read_error_o                 sticky error of the last transfer
//
// State | meaning
// IDLE  | waiting for a start edge; R channel not accepted
// ADDR  | AR request presented, waiting for arready
// DATA  | R beats passed through to the stream until beat arlen is accepted

module read_channel #(
    parameter int DMA_DATA_WIDTH_DST = 64,
    parameter int DMA_AXI_ADDR_WIDTH = 32
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_aresetn,

    output logic [DMA_AXI_ADDR_WIDTH-1:0] m_mm2s_axi_araddr,
    output logic [1:0]                    m_mm2s_axi_arburst,
    output logic [3:0]                    m_mm2s_axi_arcache,
    output logic [2:0]                    m_mm2s_axi_arprot,
    output logic [7:0]                    m_mm2s_axi_arlen,
    output logic [2:0]                    m_mm2s_axi_arsize,
    output logic                          m_mm2s_axi_arvalid,
    input  logic                          m_mm2s_axi_arready,

    input  logic [DMA_DATA_WIDTH_DST-1:0] m_mm2s_axi_rdata,
    input  logic [1:0]                    m_mm2s_axi_rresp,
    input  logic                          m_mm2s_axi_rlast,
    input  logic                          m_mm2s_axi_rvalid,
    output logic                          m_mm2s_axi_rready,

    output logic [DMA_DATA_WIDTH_DST-1:0] m_mm2s_axis_tdata,
    output logic                          m_mm2s_axis_tvalid,
    output logic                          m_mm2s_axis_tlast,
    input  logic                          m_mm2s_axis_tready,

    input  logic                          read_start_i,
    input  logic [DMA_AXI_ADDR_WIDTH-1:0] read_addr_i,
    input  logic [7:0]                    read_len_i,
    input  logic [2:0]                    read_size_i,
    output logic                          read_busy_o,
    output logic                          read_error_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       start_q;
    logic       start_edge;
    logic       load_cmd;
    logic       r_fire;
    logic       beat_last;
    logic       beat_bad;
    logic [7:0] beat_cnt;

    // Fixed AR attributes: incrementing bursts, bufferable/modifiable, unprivileged.
    assign m_mm2s_axi_arburst = 2'b01;
    assign m_mm2s_axi_arcache = 4'b0011;
    assign m_mm2s_axi_arprot  = 3'b000;

    // start_q resets to 0, so a start held high across reset release is
    // seen as a fresh edge on the first clock.
    assign start_edge = read_start_i & ~start_q;

    assign beat_last  = (beat_cnt == m_mm2s_axi_arlen);
    assign r_fire     = m_mm2s_axi_rvalid & m_mm2s_axi_rready;
    // rlast from the slave must agree with our own beat count.
    assign beat_bad   = (m_mm2s_axi_rresp != 2'b00) | (m_mm2s_axi_rlast != beat_last);

    assign m_mm2s_axis_tdata = m_mm2s_axi_rdata;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        load_cmd           = 1'b0;
        m_mm2s_axi_arvalid = 1'b0;
        m_mm2s_axi_rready  = 1'b0;
        m_mm2s_axis_tvalid = 1'b0;
        m_mm2s_axis_tlast  = 1'b0;
        read_busy_o        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    load_cmd  = 1'b1;
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                read_busy_o        = 1'b1;
                m_mm2s_axi_arvalid = 1'b1;
                if (m_mm2s_axi_arready) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                read_busy_o        = 1'b1;
                m_mm2s_axi_rready  = m_mm2s_axis_tready;
                m_mm2s_axis_tvalid = m_mm2s_axi_rvalid;
                m_mm2s_axis_tlast  = beat_last;
                if (r_fire && beat_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            start_q <= 1'b0;
        end else begin
            start_q <= read_start_i;
        end
    end

    // AR payload is only written in IDLE, so it stays stable through ADDR.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            m_mm2s_axi_araddr <= '0;
            m_mm2s_axi_arlen  <= '0;
            m_mm2s_axi_arsize <= '0;
        end else if (load_cmd) begin
            m_mm2s_axi_araddr <= read_addr_i;
            m_mm2s_axi_arlen  <= read_len_i;
            m_mm2s_axi_arsize <= read_size_i;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            beat_cnt <= '0;
        end else if (load_cmd) begin
            beat_cnt <= '0;
        end else if (r_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            read_error_o <= 1'b0;
        end else if (load_cmd) begin
            read_error_o <= 1'b0;
        end else if (r_fire && beat_bad) begin
            read_error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_read_channel.sv
module tb_read_channel;

    logic        m_axi_aclk;
    logic        m_axi_aresetn;
    logic [31:0] m_mm2s_axi_araddr;
    logic [1:0]  m_mm2s_axi_arburst;
    logic [3:0]  m_mm2s_axi_arcache;
    logic [2:0]  m_mm2s_axi_arprot;
    logic [7:0]  m_mm2s_axi_arlen;
    logic [2:0]  m_mm2s_axi_arsize;
    logic        m_mm2s_axi_arvalid;
    logic        m_mm2s_axi_arready;
    logic [63:0] m_mm2s_axi_rdata;
    logic [1:0]  m_mm2s_axi_rresp;
    logic        m_mm2s_axi_rlast;
    logic        m_mm2s_axi_rvalid;
    logic        m_mm2s_axi_rready;
    logic [63:0] m_mm2s_axis_tdata;
    logic        m_mm2s_axis_tvalid;
    logic        m_mm2s_axis_tlast;
    logic        m_mm2s_axis_tready;
    logic        read_start_i;
    logic [31:0] read_addr_i;
    logic [7:0]  read_len_i;
    logic [2:0]  read_size_i;
    logic        read_busy_o;
    logic        read_error_o;

    int n_checks = 0;
    int n_fail   = 0;
    int tid      = 0;

    read_channel #(
        .DMA_DATA_WIDTH_DST(64),
        .DMA_AXI_ADDR_WIDTH(32)
    ) dut (
        .m_axi_aclk         (m_axi_aclk),
        .m_axi_aresetn      (m_axi_aresetn),
        .m_mm2s_axi_araddr  (m_mm2s_axi_araddr),
        .m_mm2s_axi_arburst (m_mm2s_axi_arburst),
        .m_mm2s_axi_arcache (m_mm2s_axi_arcache),
        .m_mm2s_axi_arprot  (m_mm2s_axi_arprot),
        .m_mm2s_axi_arlen   (m_mm2s_axi_arlen),
        .m_mm2s_axi_arsize  (m_mm2s_axi_arsize),
        .m_mm2s_axi_arvalid (m_mm2s_axi_arvalid),
        .m_mm2s_axi_arready (m_mm2s_axi_arready),
        .m_mm2s_axi_rdata   (m_mm2s_axi_rdata),
        .m_mm2s_axi_rresp   (m_mm2s_axi_rresp),
        .m_mm2s_axi_rlast   (m_mm2s_axi_rlast),
        .m_mm2s_axi_rvalid  (m_mm2s_axi_rvalid),
        .m_mm2s_axi_rready  (m_mm2s_axi_rready),
        .m_mm2s_axis_tdata  (m_mm2s_axis_tdata),
        .m_mm2s_axis_tvalid (m_mm2s_axis_tvalid),
        .m_mm2s_axis_tlast  (m_mm2s_axis_tlast),
        .m_mm2s_axis_tready (m_mm2s_axis_tready),
        .read_start_i       (read_start_i),
        .read_addr_i        (read_addr_i),
        .read_len_i         (read_len_i),
        .read_size_i        (read_size_i),
        .read_busy_o        (read_busy_o),
        .read_error_o       (read_error_o)
    );

    initial m_axi_aclk = 1'b0;
    always #5 m_axi_aclk = ~m_axi_aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (test %0d): got 0x%0h expected 0x%0h at %0t", tag, tid, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge m_axi_aclk);
        #1;
    endtask

    // Called at posedge+1 with read_start_i low for at least one prior clock.
    task automatic do_start(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
        check("idle_before_start", 64'(read_busy_o), 64'd0);
        read_addr_i  = addr;
        read_len_i   = len;
        read_size_i  = size;
        read_start_i = 1'b1;
        tick();
        read_start_i = 1'b0;
        check("arvalid_after_edge", 64'(m_mm2s_axi_arvalid), 64'd1);
        check("busy_after_edge", 64'(read_busy_o), 64'd1);
        check("araddr_latched", 64'(m_mm2s_axi_araddr), 64'(addr));
        check("arlen_latched", 64'(m_mm2s_axi_arlen), 64'(len));
        check("arsize_latched", 64'(m_mm2s_axi_arsize), 64'(size));
        check("error_cleared", 64'(read_error_o), 64'd0);
    endtask

    // Hold arready low for 'delay' cycles while stray R beats are offered.
    task automatic wait_ar(input int delay, input logic [31:0] addr, input logic [7:0] len);
        m_mm2s_axi_arready = 1'b0;
        m_mm2s_axi_rvalid  = 1'b1;
        m_mm2s_axi_rdata   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_mm2s_axis_tready = 1'b1;
        for (int k = 0; k < delay; k++) begin
            #1;
            check("ar_wait_arvalid", 64'(m_mm2s_axi_arvalid), 64'd1);
            check("ar_wait_araddr", 64'(m_mm2s_axi_araddr), 64'(addr));
            check("ar_wait_arlen", 64'(m_mm2s_axi_arlen), 64'(len));
            check("ar_wait_rready", 64'(m_mm2s_axi_rready), 64'd0);
            check("ar_wait_tvalid", 64'(m_mm2s_axis_tvalid), 64'd0);
            tick();
        end
        m_mm2s_axi_rvalid  = 1'b0;
        m_mm2s_axi_arready = 1'b1;
        #1;
        check("arvalid_at_handshake", 64'(m_mm2s_axi_arvalid), 64'd1);
        tick();
        m_mm2s_axi_arready = 1'b0;
        check("arvalid_after_handshake", 64'(m_mm2s_axi_arvalid), 64'd0);
        check("busy_in_data", 64'(read_busy_o), 64'd1);
    endtask

    // Offer nb beats; beat i carries a tid/i tag so order and duplication show
    // up in tdata and tlast. toggle alternates tready starting with a stall.
    task automatic run_beats(input int nb, input int len, input int err_beat,
                             input int rlast_beat, input bit toggle);
        int          i;
        int          guard;
        bit          tr;
        logic [63:0] d;
        i     = 0;
        guard = 0;
        tr    = 1'b1;
        while (i < nb && guard < 100) begin
            guard++;
            tr = toggle ? ~tr : 1'b1;
            d  = {32'hC0DE_0000 | 32'(tid), 32'(i)};
            m_mm2s_axis_tready = tr;
            m_mm2s_axi_rvalid  = 1'b1;
            m_mm2s_axi_rdata   = d;
            m_mm2s_axi_rresp   = (i == err_beat) ? 2'b10 : 2'b00;
            m_mm2s_axi_rlast   = (i == rlast_beat);
            #1;
            check("rready_mirrors_tready", 64'(m_mm2s_axi_rready), 64'(tr));
            check("tvalid", 64'(m_mm2s_axis_tvalid), 64'd1);
            check("tdata", m_mm2s_axis_tdata, d);
            check("tlast", 64'(m_mm2s_axis_tlast), 64'(i == len));
            tick();
            if (tr) begin
                if (i == err_beat) check("error_after_bad_beat", 64'(read_error_o), 64'd1);
                i++;
            end
        end
        m_mm2s_axi_rvalid  = 1'b0;
        m_mm2s_axi_rlast   = 1'b0;
        m_mm2s_axi_rresp   = 2'b00;
        m_mm2s_axis_tready = 1'b1;
        check("beats_accepted", 64'(i), 64'(nb));
        if (nb == len + 1) begin
            check("busy_after_last", 64'(read_busy_o), 64'd0);
            check("tvalid_after_last", 64'(m_mm2s_axis_tvalid), 64'd0);
        end
    endtask

    initial begin
        m_axi_aresetn      = 1'b0;
        m_mm2s_axi_arready = 1'b0;
        m_mm2s_axi_rdata   = '0;
        m_mm2s_axi_rresp   = 2'b00;
        m_mm2s_axi_rlast   = 1'b0;
        m_mm2s_axi_rvalid  = 1'b0;
        m_mm2s_axis_tready = 1'b1;
        read_start_i       = 1'b0;
        read_addr_i        = '0;
        read_len_i         = '0;
        read_size_i        = '0;

        // Reset values and constant AR attributes
        #2;
        check("rst_arvalid", 64'(m_mm2s_axi_arvalid), 64'd0);
        check("rst_busy", 64'(read_busy_o), 64'd0);
        check("rst_error", 64'(read_error_o), 64'd0);
        check("rst_araddr", 64'(m_mm2s_axi_araddr), 64'd0);
        check("rst_arlen", 64'(m_mm2s_axi_arlen), 64'd0);
        check("arburst", 64'(m_mm2s_axi_arburst), 64'd1);
        check("arcache", 64'(m_mm2s_axi_arcache), 64'd3);
        check("arprot", 64'(m_mm2s_axi_arprot), 64'd0);
        tick();
        tick();
        m_axi_aresetn = 1'b1;
        tick();

        // Basic 4-beat burst
        tid = 1;
        do_start(32'h0000_1000, 8'd3, 3'd3);
        wait_ar(0, 32'h0000_1000, 8'd3);
        run_beats(4, 3, -1, 3, 1'b0);
        check("t1_error", 64'(read_error_o), 64'd0);
        tick();

        // Single beat, arready delayed
        tid = 2;
        do_start(32'h0000_2000, 8'd0, 3'd2);
        wait_ar(5, 32'h0000_2000, 8'd0);
        run_beats(1, 0, -1, 0, 1'b0);
        check("t2_error", 64'(read_error_o), 64'd0);
        tick();

        // 8 beats under alternating backpressure
        tid = 3;
        do_start(32'h0000_2400, 8'd7, 3'd3);
        wait_ar(0, 32'h0000_2400, 8'd7);
        run_beats(8, 7, -1, 7, 1'b1);
        check("t3_error", 64'(read_error_o), 64'd0);
        tick();

        // SLVERR on beat 2
        tid = 4;
        do_start(32'h0000_2800, 8'd3, 3'd3);
        wait_ar(0, 32'h0000_2800, 8'd3);
        run_beats(4, 3, 1, 3, 1'b0);
        check("t4_error_sticky", 64'(read_error_o), 64'd1);
        tick();

        // Early rlast, plus a start while busy that must be ignored
        tid = 5;
        do_start(32'h0000_2C00, 8'd3, 3'd3);
        tick();
        read_start_i = 1'b1;
        read_addr_i  = 32'hDEAD_0000;
        read_len_i   = 8'd9;
        tick();
        read_start_i = 1'b0;
        check("busy_start_araddr", 64'(m_mm2s_axi_araddr), 64'h2C00);
        check("busy_start_arlen", 64'(m_mm2s_axi_arlen), 64'd3);
        check("busy_start_arvalid", 64'(m_mm2s_axi_arvalid), 64'd1);
        wait_ar(0, 32'h0000_2C00, 8'd3);
        run_beats(4, 3, -1, 2, 1'b0);
        check("t5_error_rlast", 64'(read_error_o), 64'd1);
        tick();

        // Reset in the middle of DATA, start held through reset
        tid = 6;
        do_start(32'h0000_3000, 8'd3, 3'd3);
        wait_ar(0, 32'h0000_3000, 8'd3);
        run_beats(1, 3, 0, 3, 1'b0);
        m_mm2s_axi_rvalid  = 1'b1;
        m_mm2s_axis_tready = 1'b1;
        read_start_i       = 1'b1;
        read_addr_i        = 32'h0000_4000;
        read_len_i         = 8'd1;
        read_size_i        = 3'd3;
        #1;
        check("pre_rst_rready", 64'(m_mm2s_axi_rready), 64'd1);
        check("pre_rst_error", 64'(read_error_o), 64'd1);
        m_axi_aresetn = 1'b0;
        #1;
        check("async_rst_rready", 64'(m_mm2s_axi_rready), 64'd0);
        check("async_rst_tvalid", 64'(m_mm2s_axis_tvalid), 64'd0);
        check("async_rst_busy", 64'(read_busy_o), 64'd0);
        check("async_rst_error", 64'(read_error_o), 64'd0);
        check("async_rst_arvalid", 64'(m_mm2s_axi_arvalid), 64'd0);
        check("async_rst_araddr", 64'(m_mm2s_axi_araddr), 64'd0);
        check("async_rst_arlen", 64'(m_mm2s_axi_arlen), 64'd0);
        check("async_rst_arsize", 64'(m_mm2s_axi_arsize), 64'd0);
        check("async_rst_tlast", 64'(m_mm2s_axis_tlast), 64'd0);
        tick();
        m_mm2s_axi_rvalid = 1'b0;
        check("in_rst_busy", 64'(read_busy_o), 64'd0);
        m_axi_aresetn = 1'b1;
        tick();
        read_start_i = 1'b0;
        check("held_start_arvalid", 64'(m_mm2s_axi_arvalid), 64'd1);
        check("held_start_araddr", 64'(m_mm2s_axi_araddr), 64'h4000);
        check("held_start_arlen", 64'(m_mm2s_axi_arlen), 64'd1);
        tid = 7;
        wait_ar(1, 32'h0000_4000, 8'd1);
        run_beats(2, 1, -1, 1, 1'b0);
        check("t7_error", 64'(read_error_o), 64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
